// File: rtl/axi4_write_responder.sv
// axi4_write_responder: AXI4 write subordinate (AW/W/B) that drives a single-port memory write port.
// Define AXI_WR_PROT_CHECK_EN to make the upper half of the region secure-only.
module axi4_write_responder #(
  parameter int ID_WIDTH = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0001_0000
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [2:0]              awprot,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
  localparam int DB = DATA_WIDTH / 8;
  localparam int LB = $clog2(DB);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;
  state_e                  state_q;
  logic                    awready_q, wready_q, bvalid_q, mem_we_q, over_q;
  logic [ID_WIDTH-1:0]     bid_q, id_q;
  logic [1:0]              bresp_q, err_q, burst_q, aw_resp;
  logic [2:0]              size_q;
  logic [7:0]              len_q, beat_q;
  logic [ADDR_WIDTH-1:0]   addr_q, wrap_lo_q, wrap_len_q, mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DB-1:0]           mem_wstrb_q, lane;
  logic [ADDR_WIDTH-1:0]   off, aw_smask, aw_wlen, smask, aligned, incr, nxt;
  logic [20:0]             incr_end;
  logic                    prot_err, bad_size, bad_wrap, bad_4k;
`ifdef AXI_WR_PROT_CHECK_EN
  assign prot_err = awprot[1] && (off >= (REGION_BYTES >> 1));
`else
  logic unused_prot;
  assign unused_prot = ^awprot;
  assign prot_err = 1'b0;
`endif
  // Unsigned offset wraps below BASE_ADDR, so one compare covers both region edges.
  assign off      = awaddr - BASE_ADDR;
  assign aw_smask = (ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1);
  assign aw_wlen  = ADDR_WIDTH'((32'(awlen) + 32'd1) << awsize);
  assign incr_end = 21'(awaddr[11:0] & ~aw_smask[11:0]) + ((21'(awlen) + 21'd1) << awsize);
  assign bad_size = 32'(awsize) > LB;
  assign bad_wrap = awburst == WRAP && (!(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}) || |(awaddr & aw_smask));
  assign bad_4k   = awburst == INCR && incr_end > 21'h1000;
  assign aw_resp  = off >= REGION_BYTES ? DECERR :
                    (prot_err || awburst == 2'b11 || bad_size || bad_wrap || bad_4k) ? SLVERR : OKAY;
  assign smask    = (ADDR_WIDTH'(1) << size_q) - ADDR_WIDTH'(1);
  assign aligned  = addr_q & ~smask;
  assign incr     = aligned + smask + ADDR_WIDTH'(1);
  assign nxt      = burst_q == FIXED ? addr_q :
                    (burst_q == WRAP && incr == wrap_lo_q + wrap_len_q) ? wrap_lo_q : incr;
  always_comb begin
    lane = '0;
    for (int i = 0; i < DB; i++)
      lane[i] = (i >= int'(aligned[LB-1:0])) && (i < int'(aligned[LB-1:0]) + (1 << size_q));
  end
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      id_q        <= '0;
      addr_q      <= '0;
      wrap_lo_q   <= '0;
      wrap_len_q  <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= FIXED;
      err_q       <= OKAY;
      beat_q      <= '0;
      over_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && awvalid) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= DATA;
            id_q       <= awid;
            addr_q     <= awaddr;
            wrap_lo_q  <= awaddr & ~(aw_wlen - ADDR_WIDTH'(1));
            wrap_len_q <= aw_wlen;
            len_q      <= awlen;
            size_q     <= awsize;
            burst_q    <= awburst;
            err_q      <= aw_resp;
            beat_q     <= '0;
            over_q     <= 1'b0;
          end
        end
        DATA: begin
          if (wvalid) begin
            mem_we_q    <= err_q == OKAY && !over_q;
            mem_addr_q  <= addr_q & ~ADDR_WIDTH'(DB - 1);
            mem_wdata_q <= wdata;
            mem_wstrb_q <= wstrb & lane;
            addr_q      <= nxt;
            over_q      <= over_q || beat_q == len_q;
            beat_q      <= beat_q == len_q ? beat_q : beat_q + 8'd1;
            if (wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= err_q != OKAY ? err_q : (beat_q == len_q && !over_q) ? OKAY : SLVERR;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
endmodule
